// File: rtl/div_lp_v1.sv
// Fully pipelined unsigned restoring divider: input register, w one-bit stages, output register.
// Optional remainder output enabled by defining DIV_LP_REM_EN.
module div_lp_v1 #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [w-1:0] dN,
    input  logic [w-1:0] dD,
    output logic         out_valid,
    output logic [w-1:0] q,
`ifdef DIV_LP_REM_EN
    output logic [w-1:0] r,
`endif
    output logic         dbz
);

    // Index k holds the state entering stage k; index w is the last iteration result.
    logic [w:0]   vld_pipe;
    logic [w-1:0] n_pipe [0:w];
    logic [w-1:0] d_pipe [0:w];
    logic [w-1:0] q_pipe [0:w];
    logic [w-1:0] r_pipe [0:w];

    logic [w-1:0] q_nxt [0:w-1];
    logic [w-1:0] r_nxt [0:w-1];

    // Partial remainders fit in w bits: with D != 0 they stay below D, and with
    // D == 0 stage i holds only the top i bits of N. Only the trial value needs w+1.
    always_comb begin
        logic [w:0] t;
        logic       ge;
        t  = '0;
        ge = 1'b0;
        q_nxt = '{default: '0};
        r_nxt = '{default: '0};
        for (int i = 0; i < w; i++) begin
            t  = {r_pipe[i], n_pipe[i][w-1-i]};
            ge = (t >= {1'b0, d_pipe[i]});
            r_nxt[i] = ge ? w'(t - {1'b0, d_pipe[i]}) : t[w-1:0];
            q_nxt[i] = q_pipe[i];
            q_nxt[i][w-1-i] = ge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            for (int k = 0; k <= w; k++) begin
                n_pipe[k] <= '0;
                d_pipe[k] <= '0;
                q_pipe[k] <= '0;
                r_pipe[k] <= '0;
            end
            out_valid <= 1'b0;
            q         <= '0;
`ifdef DIV_LP_REM_EN
            r         <= '0;
`endif
            dbz       <= 1'b0;
        end else begin
            // Data is captured regardless of in_valid; only the tag qualifies it.
            vld_pipe[0] <= in_valid;
            n_pipe[0]   <= dN;
            d_pipe[0]   <= dD;
            q_pipe[0]   <= '0;
            r_pipe[0]   <= '0;
            for (int i = 0; i < w; i++) begin
                vld_pipe[i+1] <= vld_pipe[i];
                n_pipe[i+1]   <= n_pipe[i];
                d_pipe[i+1]   <= d_pipe[i];
                q_pipe[i+1]   <= q_nxt[i];
                r_pipe[i+1]   <= r_nxt[i];
            end
            out_valid <= vld_pipe[w];
            if (vld_pipe[w]) begin
                q   <= q_pipe[w];
`ifdef DIV_LP_REM_EN
                r   <= r_pipe[w];
`endif
                dbz <= (d_pipe[w] == '0);
            end
        end
    end

endmodule
